// File: rtl/pb_event_pkg.sv
`default_nettype none
// ============================================================================
// Module : pb_event_pkg
// Brief  : State encodings shared by the push-button event classifier.
// Rev    : 1.0  initial release
// ============================================================================
package pb_event_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        PRESSED = 3'd1,
        HOLD    = 3'd2,
        WAIT2   = 3'd3,
        DC_HELD = 3'd4
    } state_t;

endpackage : pb_event_pkg
`default_nettype wire

// File: rtl/pb_event_classifier.sv
`default_nettype none
// ============================================================================
// Module : pb_event_classifier
// Brief  : Turns debounced button edges into single/double/long/repeat events.
// Rev    : 1.0  initial release
// ============================================================================
module pb_event_classifier
    import pb_event_pkg::*;
#(
    parameter int CNT_WIDTH     = 27,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int DCLICK_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_state,
    input  logic pb_posedge,
    input  logic pb_negedge,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_tick,
    output logic pb_held
);

    localparam logic [CNT_WIDTH-1:0] c_LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_DCLICK_LAST = CNT_WIDTH'(DCLICK_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_next;
    logic                   w_cnt_clear;
    logic                   w_single;
    logic                   w_double;
    logic                   w_long;
    logic                   w_repeat;

    // Release always beats a timeout in pressed states; press beats it otherwise.
    always_comb begin
        w_next_state = r_state;
        w_cnt_clear  = 1'b0;
        w_single     = 1'b0;
        w_double     = 1'b0;
        w_long       = 1'b0;
        w_repeat     = 1'b0;
        case (r_state)
            IDLE: begin
                if (pb_posedge) w_next_state = PRESSED;
            end
            PRESSED: begin
                if (pb_negedge) begin
                    w_next_state = WAIT2;
                end else if (r_cnt == c_LONG_LAST) begin
                    w_next_state = HOLD;
                    w_long       = 1'b1;
                end
            end
            HOLD: begin
                if (pb_negedge) begin
                    w_next_state = IDLE;
                end else if (r_cnt == c_REPEAT_LAST) begin
                    w_repeat    = 1'b1;
                    w_cnt_clear = 1'b1;
                end
            end
            WAIT2: begin
                if (pb_posedge) begin
                    w_next_state = DC_HELD;
                    w_double     = 1'b1;
                end else if (r_cnt == c_DCLICK_LAST) begin
                    w_next_state = IDLE;
                    w_single     = 1'b1;
                end
            end
            DC_HELD: begin
                if (pb_negedge) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if ((w_next_state != r_state) || w_cnt_clear) begin
            w_cnt_next = '0;
        end else if (r_state inside {PRESSED, HOLD, WAIT2}) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            repeat_tick  <= 1'b0;
            pb_held      <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_cnt_next;
            single_click <= w_single;
            double_click <= w_double;
            long_press   <= w_long;
            repeat_tick  <= w_repeat;
            pb_held      <= (w_next_state == HOLD) && pb_state;
        end
    end

endmodule : pb_event_classifier
`default_nettype wire
